// File: rtl/carga_programa.sv
// carga_programa: program loader for the instruction-fetch stage.
// Packs the UART byte stream big-endian into instruction words and writes
// them to program memory from address 0 until the HALT word is stored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | PC owns the memory; waiting for i_start
// S_RECV  | collecting bytes of the current word
// S_WRITE | one-cycle write of the latched word at the current address
// S_DONE  | HALT stored; program ready, PC owns the memory
// S_ERROR | memory filled without HALT; nothing more is written
module carga_programa #(
   parameter int                            RAM_WIDTH_PROGRAMA = 32,
   parameter int                            CANT_BITS_ADDR     = 11,
   parameter int                            RAM_DEPTH_PROGRAMA = 2048,
   parameter logic [RAM_WIDTH_PROGRAMA-1:0] HALT_WORD          = 32'hFFFFFFFF
) (
   input  logic                          i_clock,
   input  logic                          i_soft_reset,
   input  logic                          i_start,
   input  logic                          i_rx_done,
   input  logic [7:0]                    i_rx_data,
   output logic [CANT_BITS_ADDR-1:0]     o_addr_mem_programa,
   output logic [RAM_WIDTH_PROGRAMA-1:0] o_data_mem_programa,
   output logic                          o_write_read_mem,
   output logic                          o_enable_mem,
   output logic                          o_control_mux_addr_mem,
   output logic [CANT_BITS_ADDR:0]       o_word_count,
   output logic                          o_load_done,
   output logic                          o_error
);

   localparam int BYTES_PER_WORD = RAM_WIDTH_PROGRAMA / 8;
   localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [CNT_W-1:0]          LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [CANT_BITS_ADDR-1:0] LAST_ADDR = CANT_BITS_ADDR'(RAM_DEPTH_PROGRAMA - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t                          r_state;
   state_t                          w_state_next;

   // Only the leading bytes of a word are stored; the last byte goes
   // straight from i_rx_data into the write-data register.
   logic [RAM_WIDTH_PROGRAMA-9:0]   r_shift;
   logic [CNT_W-1:0]                r_byte_cnt;
   logic [CANT_BITS_ADDR-1:0]       r_addr;
   logic [CANT_BITS_ADDR-1:0]       r_addr_out;
   logic [RAM_WIDTH_PROGRAMA-1:0]   r_data_out;
   logic [CANT_BITS_ADDR:0]         r_word_count;

   logic [RAM_WIDTH_PROGRAMA-1:0]   w_shift_next;
   logic                            w_start_ok;
   logic                            w_byte_ok;
   logic                            w_word_ready;
   logic                            w_write;
   logic                            w_mux;
   logic                            w_done;
   logic                            w_error;

   assign w_shift_next = {r_shift, i_rx_data};

   // A start is honoured only between loads; it beats a same-cycle byte.
   assign w_start_ok = i_start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

   // Bytes are taken while receiving and also during the write cycle, so a
   // stream at one byte per clock never loses data.
   assign w_byte_ok = i_rx_done && ((r_state == S_RECV) || (r_state == S_WRITE));

   assign w_word_ready = (r_state == S_RECV) && i_rx_done && (r_byte_cnt == LAST_BYTE);

   // State register
   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; HALT takes priority over the memory-full check
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (i_start) begin
               w_state_next = S_RECV;
            end
         end
         S_RECV: begin
            if (w_word_ready) begin
               w_state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (r_data_out == HALT_WORD) begin
               w_state_next = S_DONE;
            end else if (r_addr == LAST_ADDR) begin
               w_state_next = S_ERROR;
            end else begin
               w_state_next = S_RECV;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode from the current state
   always_comb begin
      w_write = 1'b0;
      w_mux   = 1'b0;
      w_done  = 1'b0;
      w_error = 1'b0;
      case (r_state)
         S_RECV: begin
            w_mux = 1'b1;
         end
         S_WRITE: begin
            w_mux   = 1'b1;
            w_write = 1'b1;
         end
         S_DONE: begin
            w_done = 1'b1;
         end
         S_ERROR: begin
            w_error = 1'b1;
         end
         default: begin
            w_write = 1'b0;
         end
      endcase
   end

   // Byte assembly, word latch, address and word-count bookkeeping
   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         r_shift      <= '0;
         r_byte_cnt   <= '0;
         r_addr       <= '0;
         r_addr_out   <= '0;
         r_data_out   <= '0;
         r_word_count <= '0;
      end else if (w_start_ok) begin
         r_shift      <= '0;
         r_byte_cnt   <= '0;
         r_addr       <= '0;
         r_word_count <= '0;
      end else begin
         if (w_byte_ok) begin
            r_shift    <= w_shift_next[RAM_WIDTH_PROGRAMA-9:0];
            r_byte_cnt <= r_byte_cnt + 1'b1;
         end
         // Latching the full word here frees the assembly register for a
         // byte that may arrive during the write cycle.
         if (w_word_ready) begin
            r_data_out <= w_shift_next;
            r_addr_out <= r_addr;
         end
         if (r_state == S_WRITE) begin
            r_addr       <= r_addr + 1'b1;
            r_word_count <= r_word_count + 1'b1;
         end
      end
   end

   assign o_addr_mem_programa    = r_addr_out;
   assign o_data_mem_programa    = r_data_out;
   assign o_write_read_mem       = w_write;
   assign o_enable_mem           = w_write;
   assign o_control_mux_addr_mem = w_mux;
   assign o_word_count           = r_word_count;
   assign o_load_done            = w_done;
   assign o_error                = w_error;

endmodule

// File: tb/tb_carga_programa.sv
// Bench for carga_programa: randomized byte streams checked against a
// word-level model of the loader (bytes -> big-endian words -> sequential
// writes, stopping at HALT or when memory is full).
module tb_carga_programa;

   localparam int          AW    = 11;
   localparam int          DW    = 32;
   localparam int          DEPTH = 2048;
   localparam logic [31:0] HALT  = 32'hFFFFFFFF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start;
   logic          i_rx_done;
   logic [7:0]    i_rx_data;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_data;
   logic          o_we;
   logic          o_en;
   logic          o_mux;
   logic [AW:0]   o_wc;
   logic          o_done;
   logic          o_err;

   int n_cmp = 0;
   int n_err = 0;

   // write record: {enable, addr, data}
   logic [43:0] act_q[$];
   logic [43:0] exp_q[$];
   logic [7:0]  mdl_bytes[$];
   logic        exp_done;
   logic        exp_err;
   logic [AW:0] exp_wc;

   carga_programa dut (
      .i_clock               (clk),
      .i_soft_reset          (rst_n),
      .i_start               (i_start),
      .i_rx_done             (i_rx_done),
      .i_rx_data             (i_rx_data),
      .o_addr_mem_programa   (o_addr),
      .o_data_mem_programa   (o_data),
      .o_write_read_mem      (o_we),
      .o_enable_mem          (o_en),
      .o_control_mux_addr_mem(o_mux),
      .o_word_count          (o_wc),
      .o_load_done           (o_done),
      .o_error               (o_err)
   );

   always #5 clk = ~clk;

   // Record every write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (o_we === 1'b1) act_q.push_back({o_en, o_addr, o_data});
   end

   // Reference model: accepted bytes grouped four at a time, first byte most
   // significant, written to consecutive addresses from 0.
   function automatic void model_compute();
      logic [31:0] word;
      exp_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_wc   = '0;
      for (int w = 0; w < mdl_bytes.size() / 4; w++) begin
         word = {mdl_bytes[4*w], mdl_bytes[4*w+1], mdl_bytes[4*w+2], mdl_bytes[4*w+3]};
         exp_q.push_back({1'b1, AW'(w), word});
         exp_wc = exp_wc + 1'b1;
         if (word == HALT) begin
            exp_done = 1'b1;
            break;
         end
         if (w == DEPTH - 1) begin
            exp_err = 1'b1;
            break;
         end
      end
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   task automatic pulse_start();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_done = 1'b1;
      i_rx_data = b;
      @(posedge clk); #1;
      i_rx_done = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         b = w[31-8*k -: 8];
         mdl_bytes.push_back(b);
         send_byte(b, $urandom_range(gmax, gmin));
      end
   endtask

   task automatic begin_load();
      act_q.delete();
      mdl_bytes.delete();
      pulse_start();
   endtask

   task automatic wait_end();
      for (int k = 0; k < 40; k++) begin
         if (o_done || o_err) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
      #7;
      n_cmp++;
      if ({o_we, o_en, o_mux, o_done, o_err} !== 5'b0) begin
         n_err++; $display("FAIL reset_strobes: got %b want 00000", {o_we, o_en, o_mux, o_done, o_err});
      end
      n_cmp++;
      if ({o_addr, o_data, o_wc} !== '0) begin
         n_err++; $display("FAIL reset_values: got addr %h data %h wc %0d want 0", o_addr, o_data, o_wc);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      act_q.delete();
      for (int k = 0; k < 8; k++) send_byte(8'($urandom), 0);
      repeat (2) begin @(posedge clk); #1; end
      n_cmp++;
      if (act_q.size() != 0) begin
         n_err++; $display("FAIL idle_ignores_rx: got %0d writes want 0", act_q.size());
      end
      n_cmp++;
      if (o_mux !== 1'b0) begin
         n_err++; $display("FAIL idle_mux: got %b want 0", o_mux);
      end
   endtask

   task automatic test_directed();
      logic [7:0] bytes_tab [8] = '{8'h00, 8'h21, 8'h08, 8'h24, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      begin_load();
      n_cmp++;
      if (o_mux !== 1'b1) begin
         n_err++; $display("FAIL dir_mux_loading: got %b want 1", o_mux);
      end
      for (int k = 0; k < 8; k++) begin
         mdl_bytes.push_back(bytes_tab[k]);
         send_byte(bytes_tab[k], 2);
      end
      wait_end();
      n_cmp++;
      if (act_q.size() != 2) begin
         n_err++; $display("FAIL dir_nwrites: got %0d want 2", act_q.size());
      end else begin
         n_cmp++;
         if (act_q[0] !== {1'b1, 11'd0, 32'h00210824}) begin
            n_err++; $display("FAIL dir_write0: got %h want %h", act_q[0], {1'b1, 11'd0, 32'h00210824});
         end
         n_cmp++;
         if (act_q[1] !== {1'b1, 11'd1, 32'hFFFFFFFF}) begin
            n_err++; $display("FAIL dir_write1: got %h want %h", act_q[1], {1'b1, 11'd1, 32'hFFFFFFFF});
         end
      end
      n_cmp++;
      if ({o_done, o_err, o_mux, o_wc} !== {1'b1, 1'b0, 1'b0, 12'd2}) begin
         n_err++; $display("FAIL dir_status: got done %b err %b mux %b wc %0d want 1 0 0 2", o_done, o_err, o_mux, o_wc);
      end
      n_cmp++;
      if ({o_we, o_en, o_addr, o_data} !== {1'b0, 1'b0, 11'd1, 32'hFFFFFFFF}) begin
         n_err++; $display("FAIL dir_hold: got we %b en %b addr %0d data %h want 0 0 1 ffffffff", o_we, o_en, o_addr, o_data);
      end
   endtask

   task automatic test_back_to_back();
      begin_load();
      send_word(rand_word(), 0, 0);
      send_word(rand_word(), 0, 0);
      repeat (2) begin @(posedge clk); #1; end
      model_compute();
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL b2b_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         n_cmp++;
         if (act_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL b2b_write%0d: got %h want %h", i, act_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if ({o_mux, o_done} !== 2'b10) begin
         n_err++; $display("FAIL b2b_loading: got mux %b done %b want 1 0", o_mux, o_done);
      end
      send_word(HALT, 0, 0);
      wait_end();
      model_compute();
      n_cmp++;
      if ({act_q.size() == 3, o_done, o_wc} !== {1'b1, exp_done, exp_wc}) begin
         n_err++; $display("FAIL b2b_halt: got nw %0d done %b wc %0d want 3 %b %0d", act_q.size(), o_done, o_wc, exp_done, exp_wc);
      end
   endtask

   task automatic test_random();
      int nw;
      for (int r = 0; r < 4; r++) begin
         begin_load();
         nw = $urandom_range(12, 1);
         for (int k = 0; k < nw; k++) send_word(rand_word(), 0, 3);
         send_word(HALT, 0, 3);
         wait_end();
         model_compute();
         n_cmp++;
         if (act_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", r, act_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < act_q.size()) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL rnd%0d_write%0d: got %h want %h", r, i, act_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if ({o_done, o_err, o_wc} !== {exp_done, exp_err, exp_wc}) begin
            n_err++; $display("FAIL rnd%0d_status: got %b %b %0d want %b %b %0d", r, o_done, o_err, o_wc, exp_done, exp_err, exp_wc);
         end
      end
   endtask

   task automatic test_start_midword();
      logic [31:0] w;
      logic [7:0]  b;
      begin_load();
      w = rand_word();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) pulse_start();
         b = w[31-8*k -: 8];
         mdl_bytes.push_back(b);
         send_byte(b, 1);
      end
      send_word(HALT, 0, 1);
      wait_end();
      model_compute();
      n_cmp++;
      if (act_q.size() != 2) begin
         n_err++; $display("FAIL midstart_nwrites: got %0d want 2", act_q.size());
      end else begin
         n_cmp++;
         if (act_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL midstart_word: got %h want %h", act_q[0], exp_q[0]);
         end
      end
      n_cmp++;
      if ({o_done, o_wc} !== {1'b1, 12'd2}) begin
         n_err++; $display("FAIL midstart_status: got done %b wc %0d want 1 2", o_done, o_wc);
      end
   endtask

   task automatic test_reset_midload();
      logic [31:0] w;
      begin_load();
      w = rand_word();
      for (int k = 0; k < 3; k++) send_byte(w[31-8*k -: 8], 1);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_we, o_en, o_mux, o_done, o_err, o_addr, o_data, o_wc} !== '0) begin
         n_err++; $display("FAIL midreset_outputs: got we %b en %b mux %b done %b err %b addr %h data %h wc %0d want all 0",
                           o_we, o_en, o_mux, o_done, o_err, o_addr, o_data, o_wc);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      begin_load();
      send_word(rand_word(), 0, 2);
      send_word(HALT, 0, 2);
      wait_end();
      model_compute();
      n_cmp++;
      if (act_q.size() != 2) begin
         n_err++; $display("FAIL midreset_nwrites: got %0d want 2", act_q.size());
      end else begin
         n_cmp++;
         if (act_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL midreset_fresh_word: got %h want %h", act_q[0], exp_q[0]);
         end
      end
   endtask

   task automatic test_restart_from_done();
      n_cmp++;
      if (o_done !== 1'b1) begin
         n_err++; $display("FAIL restart_pre_done: got %b want 1", o_done);
      end
      act_q.delete();
      mdl_bytes.delete();
      // start together with a byte: the byte must be dropped
      i_start   = 1'b1;
      i_rx_done = 1'b1;
      i_rx_data = 8'h5A;
      @(posedge clk); #1;
      i_start   = 1'b0;
      i_rx_done = 1'b0;
      n_cmp++;
      if ({o_done, o_mux, o_wc} !== {1'b0, 1'b1, 12'd0}) begin
         n_err++; $display("FAIL restart_clear: got done %b mux %b wc %0d want 0 1 0", o_done, o_mux, o_wc);
      end
      send_word(rand_word(), 0, 2);
      send_word(HALT, 0, 2);
      wait_end();
      model_compute();
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL restart_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         n_cmp++;
         if (act_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL restart_write%0d: got %h want %h", i, act_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if ({o_done, o_wc} !== {1'b1, 12'd2}) begin
         n_err++; $display("FAIL restart_status: got done %b wc %0d want 1 2", o_done, o_wc);
      end
   endtask

   task automatic test_fill();
      int nbad;
      begin_load();
      for (int k = 0; k < DEPTH; k++) send_word(rand_word(), 0, 0);
      wait_end();
      model_compute();
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL fill_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
      end
      nbad = 0;
      foreach (exp_q[i]) if (i < act_q.size()) begin
         n_cmp++;
         if (act_q[i] !== exp_q[i]) begin
            n_err++;
            if (nbad < 5) $display("FAIL fill_write%0d: got %h want %h", i, act_q[i], exp_q[i]);
            nbad++;
         end
      end
      n_cmp++;
      if ({o_err, o_done, o_mux, o_wc} !== {exp_err, 1'b0, 1'b0, exp_wc}) begin
         n_err++; $display("FAIL fill_status: got err %b done %b mux %b wc %0d want %b 0 0 %0d", o_err, o_done, o_mux, o_wc, exp_err, exp_wc);
      end
      for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (act_q.size() != DEPTH) begin
         n_err++; $display("FAIL fill_no_extra_write: got %0d writes want %0d", act_q.size(), DEPTH);
      end
      pulse_start();
      n_cmp++;
      if ({o_err, o_mux} !== 2'b01) begin
         n_err++; $display("FAIL fill_restart: got err %b mux %b want 0 1", o_err, o_mux);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_start_midword();
      test_reset_midload();
      test_restart_from_done();
      test_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/carga_programa.md
Name: carga_programa

Overview:
- Upstream loader for the instruction-fetch stage.
- Assembles a byte stream from the UART receiver into 32-bit instruction words and writes them sequentially into program memory from address 0.
- Drives the fetch stage's memory write port and its address-mux select while loading.
- Releases the memory to the PC once the HALT word has been written.

Parameters:
- RAM_WIDTH_PROGRAMA, 32, instruction word width; must equal 4 bytes.
- CANT_BITS_ADDR, 11, program memory address width.
- RAM_DEPTH_PROGRAMA, 2048, number of words; must be at most 2^CANT_BITS_ADDR.
- HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is written to memory, then loading ends.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_soft_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that begins a new load.
- i_rx_done  in  1  one-cycle strobe meaning i_rx_data is valid.
- i_rx_data  in  8  received byte.
- o_addr_mem_programa  out  CANT_BITS_ADDR  write address to program memory.
- o_data_mem_programa  out  RAM_WIDTH_PROGRAMA  write data to program memory.
- o_write_read_mem  out  1  write strobe: 1 = write.
- o_enable_mem  out  1  memory enable during a write.
- o_control_mux_addr_mem  out  1  1 = loader owns the memory address; 0 = PC owns it.
- o_word_count  out  CANT_BITS_ADDR+1  words written in the current load.
- o_load_done  out  1  level; HALT written, program ready.
- o_error  out  1  level; memory filled without HALT.

Behaviour:
- Reset (asynchronous, i_soft_reset=0):
  - State = IDLE.
  - All outputs 0; byte counter 0; address 0; assembly register 0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - o_control_mux_addr_mem=0; i_rx_done is ignored.
  - i_start: go to RECV; clear address, byte counter and word count; set o_control_mux_addr_mem=1.
- RECV:
  - Each i_rx_done shifts the byte into the assembly register, big-endian: the first byte lands in bits [31:24]. Byte counter increments.
  - On the 4th byte (counter wraps 3→0), the next cycle is WRITE.
  - The assembled word is copied into the write-data register in the same edge, so the assembly register is free.
- WRITE (exactly 1 cycle):
  - o_write_read_mem=1 and o_enable_mem=1.
  - o_addr_mem_programa = current address; o_data_mem_programa = latched word.
  - Write latency is 1 cycle: the word is in memory on the edge that ends WRITE.
  - On exit: address+1, o_word_count+1.
  - Exit priority: word==HALT_WORD → DONE; else address==RAM_DEPTH_PROGRAMA-1 → ERROR; else → RECV.
- Strobes outside WRITE:
  - o_write_read_mem and o_enable_mem are 0 in every other state.
  - o_addr_mem_programa and o_data_mem_programa hold their last values.
- Byte arriving during WRITE: it is accepted into the assembly register as byte 0 of the next word and must not be lost, so back-to-back bytes at 1 per cycle are sustained.
- DONE:
  - o_load_done=1; o_control_mux_addr_mem=0; o_word_count holds.
  - i_rx_done is ignored.
  - i_start behaves as in IDLE and clears o_load_done.
- ERROR:
  - o_error=1; o_control_mux_addr_mem=0; nothing further is written.
  - i_start behaves as in IDLE and clears o_error.
- i_start in RECV or WRITE: ignored; no restart mid-word.
- i_start and i_rx_done in the same cycle while in IDLE/DONE/ERROR: start wins and the byte is dropped.
- Address never wraps: the ERROR check makes it impossible to write address 0 twice in one load.
- Reset mid-load: immediate return to IDLE with outputs 0. A write strobe may be truncated; the memory contents are undefined only at the address being written.

Test Plan:
- Reset then i_start; bytes 00,21,08,24 then FF,FF,FF,FF, each 3 cycles apart:
  - write addr 0, data 32'h00210824;
  - write addr 1, data FFFFFFFF;
  - then o_load_done=1, o_word_count=2, o_control_mux_addr_mem=0.
- Eight bytes on consecutive cycles (i_rx_done held high): two writes at addr 0 and 1 with the correct words, no byte dropped.
- Stream 2048 non-HALT words: last write at addr 2047, then o_error=1, no 2049th write strobe, o_word_count=2048.
- i_start pulsed after the 2nd byte of a word: ignored; the word completes and is written normally.
- Assert reset after the 3rd byte: all outputs 0 asynchronously. A new i_start then loads the next 4 bytes as a fresh word at addr 0.
- From DONE, issue i_start and one word plus HALT: o_load_done drops on start, rises again, o_word_count=2, and the first write is at addr 0.
